// File: rtl/demux_ctrl_pkg.sv
// Shared types and constants for the 1x2 demux sequencing controller.
// Optional build macro used by the slice: DEMUX_CTRL_CNT_EN (per-channel
// transfer counters).
package demux_ctrl_pkg;

  // Controller state: IDLE = holding register empty, SEND = beat on offer.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Destination selection modes.
  localparam int MODE_DEST = 0;
  localparam int MODE_RR   = 1;

  // Channel encodings used for tgt, rr_ptr and sel_last.
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Picks the channel for a newly captured beat.
  function automatic logic pick_target(input int mode, input logic dest, input logic rr_ptr);
    return (mode == MODE_DEST) ? dest : rr_ptr;
  endfunction

endpackage : demux_ctrl_pkg

// File: rtl/demux_ctrl_cnt.sv
// Wrapping transfer counter, one per output channel.
// Only compiled when DEMUX_CTRL_CNT_EN is defined.
`ifdef DEMUX_CTRL_CNT_EN
module demux_ctrl_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  // Count accepted transfers; natural binary overflow gives the wrap to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule : demux_ctrl_cnt
`endif

// File: rtl/demux_1x2_ctrl.sv
// Sequencing controller for a 1x2 demux: one valid/ready input stream is
// steered beat by beat to channel A or B through a one-entry holding
// register. Channel comes from in_dest (MODE 0) or a round-robin pointer
// (MODE 1). Define DEMUX_CTRL_CNT_EN to add a_cnt/b_cnt transfer counters.
module demux_1x2_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MODE   = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dest,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] a_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [DATA_W-1:0] b_data,
  output logic              busy,
  output logic              sel_last
`ifdef DEMUX_CTRL_CNT_EN
  ,
  output logic [CNT_W-1:0]  a_cnt,
  output logic [CNT_W-1:0]  b_cnt
`endif
);

  state_t             state_reg;
  logic [DATA_W-1:0]  hold_data_reg;
  logic               tgt_reg;
  logic               rr_ptr_reg;
  logic               sel_last_reg;

  logic               a_fire;
  logic               b_fire;
  logic               out_fire;
  logic               in_fire;
  logic               tgt_next;

  // Only the targeted channel sees valid; both see the held payload.
  assign a_valid  = (state_reg == SEND) && (tgt_reg == CH_A);
  assign b_valid  = (state_reg == SEND) && (tgt_reg == CH_B);
  assign a_data   = hold_data_reg;
  assign b_data   = hold_data_reg;
  assign busy     = (state_reg == SEND);
  assign sel_last = sel_last_reg;

  // Ready of the non-target channel is masked by its zero valid.
  assign a_fire   = a_valid && a_ready;
  assign b_fire   = b_valid && b_ready;
  assign out_fire = a_fire || b_fire;

  // in_ready never looks at in_valid, so no valid->ready loop is created.
  // In SEND a new beat is taken only when the held one leaves this cycle.
  assign in_ready = (state_reg == IDLE) ? 1'b1 : out_fire;
  assign in_fire  = in_valid && in_ready;

  assign tgt_next = pick_target(MODE, in_dest, rr_ptr_reg);

  // State, holding register and channel bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      hold_data_reg <= '0;
      tgt_reg       <= CH_A;
      rr_ptr_reg    <= CH_A;
      sel_last_reg  <= CH_A;
    end else begin
      if (in_fire) begin
        // Capture (also covers back-to-back refill while draining).
        state_reg     <= SEND;
        hold_data_reg <= in_data;
        tgt_reg       <= tgt_next;
        sel_last_reg  <= tgt_next;
        if (MODE == MODE_RR) begin
          rr_ptr_reg <= ~rr_ptr_reg;
        end
      end else if (out_fire) begin
        state_reg <= IDLE;
      end
    end
  end

`ifdef DEMUX_CTRL_CNT_EN
  demux_ctrl_cnt #(.CNT_W(CNT_W)) u_a_cnt (
    .clk (clk),
    .rst (rst),
    .inc (a_fire),
    .cnt (a_cnt)
  );

  demux_ctrl_cnt #(.CNT_W(CNT_W)) u_b_cnt (
    .clk (clk),
    .rst (rst),
    .inc (b_fire),
    .cnt (b_cnt)
  );
`endif

endmodule : demux_1x2_ctrl

// File: tb/tb_demux_1x2_ctrl.sv
// Self-checking bench for demux_1x2_ctrl: a table of per-cycle vectors on a
// MODE 0 instance, plus hand-written round-robin / mid-operation reset and
// (with DEMUX_CTRL_CNT_EN) counter sequences on a MODE 1 / MODE 0 instance.
module tb_demux_1x2_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // MODE 0 instance signals
  logic       d_rst, d_in_valid, d_in_ready, d_in_dest;
  logic [7:0] d_in_data, d_a_data, d_b_data;
  logic       d_a_valid, d_a_ready, d_b_valid, d_b_ready, d_busy, d_sel_last;
  // MODE 1 instance signals
  logic       r_rst, r_in_valid, r_in_ready, r_in_dest;
  logic [7:0] r_in_data, r_a_data, r_b_data;
  logic       r_a_valid, r_a_ready, r_b_valid, r_b_ready, r_busy, r_sel_last;
`ifdef DEMUX_CTRL_CNT_EN
  logic [1:0] d_a_cnt, d_b_cnt, r_a_cnt, r_b_cnt;
`endif

  demux_1x2_ctrl #(.DATA_W(8), .MODE(0), .CNT_W(2)) u_dest (
    .clk(clk), .rst(d_rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data), .in_dest(d_in_dest),
    .a_valid(d_a_valid), .a_ready(d_a_ready), .a_data(d_a_data),
    .b_valid(d_b_valid), .b_ready(d_b_ready), .b_data(d_b_data),
    .busy(d_busy), .sel_last(d_sel_last)
`ifdef DEMUX_CTRL_CNT_EN
    , .a_cnt(d_a_cnt), .b_cnt(d_b_cnt)
`endif
  );

  demux_1x2_ctrl #(.DATA_W(8), .MODE(1), .CNT_W(2)) u_rr (
    .clk(clk), .rst(r_rst),
    .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data), .in_dest(r_in_dest),
    .a_valid(r_a_valid), .a_ready(r_a_ready), .a_data(r_a_data),
    .b_valid(r_b_valid), .b_ready(r_b_ready), .b_data(r_b_data),
    .busy(r_busy), .sel_last(r_sel_last)
`ifdef DEMUX_CTRL_CNT_EN
    , .a_cnt(r_a_cnt), .b_cnt(r_b_cnt)
`endif
  );

  typedef struct {
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_dest;
    logic       a_ready;
    logic       b_ready;
    logic       e_av;
    logic       e_bv;
    logic [7:0] e_data;
    logic       e_ir;
    logic       e_busy;
    logic       e_sel;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One MODE 1 cycle: drive, check before the edge, step past the edge.
  task automatic rcyc(input int idx, input logic rst, input logic iv, input logic [7:0] d,
                      input logic ar, input logic br,
                      input logic eav, input logic ebv, input logic [7:0] edata,
                      input logic eir, input logic ebusy);
    r_rst = rst; r_in_valid = iv; r_in_data = d; r_in_dest = 1'b1;
    r_a_ready = ar; r_b_ready = br;
    @(negedge clk);
    $display("rr cycle %0d: rst=%0b iv=%0b d=%02h | av=%0b bv=%0b data=%02h ir=%0b busy=%0b",
             idx, rst, iv, d, r_a_valid, r_b_valid, r_a_data, r_in_ready, r_busy);
    chk($sformatf("rr%0d a_valid", idx), 32'(r_a_valid), 32'(eav));
    chk($sformatf("rr%0d b_valid", idx), 32'(r_b_valid), 32'(ebv));
    chk($sformatf("rr%0d a_data", idx), 32'(r_a_data), 32'(edata));
    chk($sformatf("rr%0d b_data", idx), 32'(r_b_data), 32'(edata));
    chk($sformatf("rr%0d in_ready", idx), 32'(r_in_ready), 32'(eir));
    chk($sformatf("rr%0d busy", idx), 32'(r_busy), 32'(ebusy));
    @(posedge clk); #1;
  endtask

  initial begin
    // in_valid, data, dest, a_ready, b_ready | a_v, b_v, data, in_ready, busy, sel_last
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1};
    vecs[6]  = vecs[5];
    vecs[7]  = vecs[5];
    vecs[8]  = vecs[5];
    vecs[9]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0};

    // Both instances in reset for two edges with in_valid high.
    d_rst = 1'b1; d_in_valid = 1'b1; d_in_data = 8'hEE; d_in_dest = 1'b1;
    d_a_ready = 1'b1; d_b_ready = 1'b1;
    r_rst = 1'b1; r_in_valid = 1'b1; r_in_data = 8'hEE; r_in_dest = 1'b1;
    r_a_ready = 1'b1; r_b_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    d_rst = 1'b0;

    // MODE 0 table: steering, back-to-back, backpressure, ignored non-target ready.
    for (int i = 0; i < 13; i++) begin
      d_in_valid = vecs[i].in_valid; d_in_data = vecs[i].in_data; d_in_dest = vecs[i].in_dest;
      d_a_ready = vecs[i].a_ready; d_b_ready = vecs[i].b_ready;
      @(negedge clk);
      $display("dest row %0d: iv=%0b d=%02h dst=%0b ar=%0b br=%0b | av=%0b bv=%0b data=%02h ir=%0b busy=%0b sel=%0b",
               i, d_in_valid, d_in_data, d_in_dest, d_a_ready, d_b_ready,
               d_a_valid, d_b_valid, d_a_data, d_in_ready, d_busy, d_sel_last);
      chk($sformatf("row%0d a_valid", i), 32'(d_a_valid), 32'(vecs[i].e_av));
      chk($sformatf("row%0d b_valid", i), 32'(d_b_valid), 32'(vecs[i].e_bv));
      chk($sformatf("row%0d a_data", i), 32'(d_a_data), 32'(vecs[i].e_data));
      chk($sformatf("row%0d b_data", i), 32'(d_b_data), 32'(vecs[i].e_data));
      chk($sformatf("row%0d in_ready", i), 32'(d_in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("row%0d busy", i), 32'(d_busy), 32'(vecs[i].e_busy));
      chk($sformatf("row%0d sel_last", i), 32'(d_sel_last), 32'(vecs[i].e_sel));
      @(posedge clk); #1;
    end

    // MODE 1: round-robin with an A stall, then reset while holding 0x77.
    r_rst = 1'b0;
    //       idx rst iv  data   ar    br   | av    bv    data   ir    busy
    rcyc(0,  1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    rcyc(1,  1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
    rcyc(2,  1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1);
    rcyc(3,  1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1);
    rcyc(4,  1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1);
    rcyc(5,  1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
    rcyc(6,  1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1);
    rcyc(7,  1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0);
    rcyc(8,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
    rcyc(9,  1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
    rcyc(10, 1'b0, 1'b1, 8'h88, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    rcyc(11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h88, 1'b1, 1'b1);

`ifdef DEMUX_CTRL_CNT_EN
    // Five streamed transfers to A on a 2-bit counter: 1,2,3,0,1; B stays 0.
    begin
      logic [1:0] seq[5];
      seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
      d_rst = 1'b1; d_in_valid = 1'b0;
      @(posedge clk); #1;
      d_rst = 1'b0; d_a_ready = 1'b1; d_b_ready = 1'b1;
      for (int j = 0; j < 7; j++) begin
        d_in_valid = (j < 5); d_in_data = 8'(j + 8'hA0); d_in_dest = 1'b0;
        @(negedge clk);
        if (j >= 2) begin
          $display("cnt cycle %0d: a_cnt=%0d b_cnt=%0d", j, d_a_cnt, d_b_cnt);
          chk($sformatf("a_cnt step%0d", j - 2), 32'(d_a_cnt), 32'(seq[j-2]));
          chk($sformatf("b_cnt step%0d", j - 2), 32'(d_b_cnt), 32'd0);
        end
        @(posedge clk); #1;
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_demux_1x2_ctrl

// File: doc/demux_1x2_ctrl.md
Name: demux_1x2_ctrl

Overview:
- Sequencing controller in front of the 1x2 demux datapath.
- Accepts a single valid/ready input stream and steers each beat to output channel A or B.
- Holds the beat in a one-entry register until the selected channel accepts it.
- Selection comes either from a per-beat destination bit or from an internal round-robin pointer. Sits between a producer and two independent consumers.

Parameters:
- DATA_W, 8, width of the data beat.
- MODE, 0, 0 = destination from in_dest; 1 = round-robin, in_dest ignored.
- CNT_W, 8, width of the optional transfer counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  controller accepts the beat this cycle.
- in_data  input  DATA_W  beat payload.
- in_dest  input  1  0 = channel A, 1 = channel B (MODE 0 only).
- a_valid  output  1  channel A beat valid.
- a_ready  input  1  channel A consumer ready.
- a_data  output  DATA_W  channel A payload.
- b_valid  output  1  channel B beat valid.
- b_ready  input  1  channel B consumer ready.
- b_data  output  DATA_W  channel B payload.
- busy  output  1  holding register occupied (state SEND).
- sel_last  output  1  channel of the most recently captured beat (0 = A, 1 = B).

Behaviour:
- Reset values (sync, rst=1 at a clk edge): state IDLE; a_valid=b_valid=0; hold_data=0; a_data=b_data=0; tgt=0; rr_ptr=0; sel_last=0; busy=0.
- Handshakes:
  - Input fire: in_valid && in_ready.
  - Output fire: (a_valid && a_ready) || (b_valid && b_ready).
- FSM states:
  - IDLE: in_ready=1. On input fire, capture in_data into hold_data and set tgt = (MODE==0 ? in_dest : rr_ptr). Then sel_last<=tgt, and in MODE 1 rr_ptr toggles. Go to SEND.
  - SEND: assert the valid of channel tgt only; a_data and b_data both show hold_data. The other channel's valid is 0.
    - in_ready = output fire (combinational from a_ready/b_ready).
    - Output fire with input fire: capture the new beat in the same cycle and stay in SEND. This gives full throughput, one beat per cycle.
    - Output fire without input fire: go to IDLE.
    - No output fire: hold. Valid stays high and data stays stable until accepted; never withdrawn.
- Latency: input fire in cycle N -> output valid in cycle N+1 (one register stage).
- Ready on the non-target channel is ignored.
- Round-robin: the first beat after reset goes to A, then B, A, ... The pointer advances only on input fire, never on stall.
- Reset mid-operation: the held beat is discarded, both valids drop in the reset cycle, and rr_ptr returns to A.
- No combinational path from in_valid to in_ready. in_ready depends only on state, tgt, a_ready and b_ready.

Optional Feature:
- DEMUX_CTRL_CNT_EN defined:
  - Adds outputs a_cnt and b_cnt (CNT_W each).
  - Each increments by 1 on its channel's output fire and wraps from 2^CNT_W-1 to 0.
  - Both clear on rst.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package demux_ctrl_pkg:
  - State enum {IDLE, SEND}.
  - Mode constants MODE_DEST=0 and MODE_RR=1.
  - Channel constants CH_A=0 and CH_B=1.
- Optional sub-module demux_ctrl_cnt: the wrapping transfer counter, instantiated twice under DEMUX_CTRL_CNT_EN.
- The demux datapath itself is kept inline.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> a_valid=b_valid=0, busy=0, in_ready=1 after release.
- MODE 0 steering: send 0x11 with dest=0, then 0x22 with dest=1, with a_ready=b_ready=1 -> a_data=0x11 valid in cycle N+1, b_data=0x22 valid in N+2, no IDLE gap between them.
- Backpressure: send 0x5A with dest=1 and b_ready=0 for 4 cycles -> b_valid=1 with b_data=0x5A stable and in_ready=0 throughout. On the cycle b_ready rises, the transfer completes and in_ready=1 in that same cycle.
- MODE 1 round-robin: 4 back-to-back beats 0x01–0x04 with in_dest=1 -> A gets 0x01 and 0x03, B gets 0x02 and 0x04. A stalled A (a_ready=0 for 2 cycles) delays the sequence but does not skip B.
- Reset mid-operation: assert rst while holding 0x77 stalled on A -> a_valid=0 next cycle. The next beat after reset (MODE 1) goes to A.
- DEMUX_CTRL_CNT_EN with CNT_W=2: 5 transfers to A -> a_cnt sequence 1,2,3,0,1 and b_cnt=0.
